// File: rtl/alu_pkg.sv
// Shared ALU opcode encoding, MIPS opcode/funct constants and the decoded-bundle
// payload passed from decode to execute.
package alu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned ALU_W  = 5;
  localparam int unsigned IMM_W  = 16;

  typedef enum logic [ALU_W-1:0] {
    ALU_SLL     = 5'b00000,
    ALU_SRL     = 5'b00001,
    ALU_SRA     = 5'b00010,
    ALU_SLLV    = 5'b00011,
    ALU_SRLV    = 5'b00100,
    ALU_SRAV    = 5'b00101,
    ALU_ADD     = 5'b00110,
    ALU_ADDU    = 5'b00111,
    ALU_SUB     = 5'b01000,
    ALU_SUBU    = 5'b01001,
    ALU_AND     = 5'b01010,
    ALU_OR      = 5'b01011,
    ALU_XOR     = 5'b01100,
    ALU_NOR     = 5'b01101,
    ALU_SLT     = 5'b01110,
    ALU_SLTU    = 5'b01111,
    ALU_LUI     = 5'b10000,
    ALU_ILLEGAL = 5'b11111
  } alu_op_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0a;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'h0b;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0c;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0d;
  localparam logic [OP_W-1:0] OP_XORI  = 6'h0e;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0f;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2b;

  localparam logic [OP_W-1:0] FN_SLL  = 6'h00;
  localparam logic [OP_W-1:0] FN_SRL  = 6'h02;
  localparam logic [OP_W-1:0] FN_SRA  = 6'h03;
  localparam logic [OP_W-1:0] FN_SLLV = 6'h04;
  localparam logic [OP_W-1:0] FN_SRLV = 6'h06;
  localparam logic [OP_W-1:0] FN_SRAV = 6'h07;
  localparam logic [OP_W-1:0] FN_ADD  = 6'h20;
  localparam logic [OP_W-1:0] FN_ADDU = 6'h21;
  localparam logic [OP_W-1:0] FN_SUB  = 6'h22;
  localparam logic [OP_W-1:0] FN_SUBU = 6'h23;
  localparam logic [OP_W-1:0] FN_AND  = 6'h24;
  localparam logic [OP_W-1:0] FN_OR   = 6'h25;
  localparam logic [OP_W-1:0] FN_XOR  = 6'h26;
  localparam logic [OP_W-1:0] FN_NOR  = 6'h27;
  localparam logic [OP_W-1:0] FN_SLT  = 6'h2a;
  localparam logic [OP_W-1:0] FN_SLTU = 6'h2b;

  typedef struct packed {
    alu_op_e           alu_control;
    logic [REG_W-1:0]  shamt;
    logic [REG_W-1:0]  rs_addr;
    logic [REG_W-1:0]  rt_addr;
    logic [REG_W-1:0]  dest_addr;
    logic [XLEN-1:0]   imm32;
    logic              use_imm;
    logic              reg_write;
    logic              is_load;
    logic              is_store;
    logic              illegal;
  } dec_bundle_t;

  function automatic logic [XLEN-1:0] sext16(input logic [IMM_W-1:0] v);
    return {{(XLEN-IMM_W){v[IMM_W-1]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zext16(input logic [IMM_W-1:0] v);
    return {{(XLEN-IMM_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/alu_ctrl_decode_comb.sv
// Pure combinational MIPS instruction decode into the ALU control bundle.
module alu_ctrl_decode_comb
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output dec_bundle_t     bundle_c
);

  logic [OP_W-1:0]  opcode;
  logic [OP_W-1:0]  funct;
  logic [IMM_W-1:0] imm16;
  logic             legal;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign imm16  = instr[15:0];

  always_comb begin
    legal            = 1'b1;
    bundle_c         = '0;
    bundle_c.rs_addr = instr[25:21];
    bundle_c.rt_addr = instr[20:16];

    if (opcode == OP_RTYPE) begin
      bundle_c.dest_addr = instr[15:11];
      bundle_c.shamt     = instr[10:6];
      case (funct)
        FN_SLL:  bundle_c.alu_control = ALU_SLL;
        FN_SRL:  bundle_c.alu_control = ALU_SRL;
        FN_SRA:  bundle_c.alu_control = ALU_SRA;
        FN_SLLV: bundle_c.alu_control = ALU_SLLV;
        FN_SRLV: bundle_c.alu_control = ALU_SRLV;
        FN_SRAV: bundle_c.alu_control = ALU_SRAV;
        FN_ADD:  bundle_c.alu_control = ALU_ADD;
        FN_ADDU: bundle_c.alu_control = ALU_ADDU;
        FN_SUB:  bundle_c.alu_control = ALU_SUB;
        FN_SUBU: bundle_c.alu_control = ALU_SUBU;
        FN_AND:  bundle_c.alu_control = ALU_AND;
        FN_OR:   bundle_c.alu_control = ALU_OR;
        FN_XOR:  bundle_c.alu_control = ALU_XOR;
        FN_NOR:  bundle_c.alu_control = ALU_NOR;
        FN_SLT:  bundle_c.alu_control = ALU_SLT;
        FN_SLTU: bundle_c.alu_control = ALU_SLTU;
        default: legal = 1'b0;
      endcase
    end else begin
      bundle_c.use_imm   = 1'b1;
      bundle_c.dest_addr = instr[20:16];
      bundle_c.imm32     = sext16(imm16);
      case (opcode)
        OP_ADDI:  bundle_c.alu_control = ALU_ADD;
        OP_ADDIU: bundle_c.alu_control = ALU_ADDU;
        OP_SLTI:  bundle_c.alu_control = ALU_SLT;
        OP_SLTIU: bundle_c.alu_control = ALU_SLTU;
        OP_ANDI: begin
          bundle_c.alu_control = ALU_AND;
          bundle_c.imm32       = zext16(imm16);
        end
        OP_ORI: begin
          bundle_c.alu_control = ALU_OR;
          bundle_c.imm32       = zext16(imm16);
        end
        OP_XORI: begin
          bundle_c.alu_control = ALU_XOR;
          bundle_c.imm32       = zext16(imm16);
        end
        // the ALU does the <<16 itself, so the raw immediate is passed through
        OP_LUI: begin
          bundle_c.alu_control = ALU_LUI;
          bundle_c.imm32       = zext16(imm16);
        end
        OP_LW: begin
          bundle_c.alu_control = ALU_ADDU;
          bundle_c.is_load     = 1'b1;
        end
        OP_SW: begin
          bundle_c.alu_control = ALU_ADDU;
          bundle_c.is_store    = 1'b1;
        end
        default: legal = 1'b0;
      endcase
    end

    // undecoded encodings still travel down the pipe, but with no side effects
    if (!legal) begin
      bundle_c             = '0;
      bundle_c.rs_addr     = instr[25:21];
      bundle_c.rt_addr     = instr[20:16];
      bundle_c.alu_control = ALU_ILLEGAL;
      bundle_c.illegal     = 1'b1;
    end

    bundle_c.reg_write = legal && !bundle_c.is_store && (bundle_c.dest_addr != '0);
  end

endmodule

// File: rtl/alu_ctrl_decode.sv
// Registered decode stage: decodes on accept into a 2-entry skid FIFO whose head
// register drives the output bundle directly.
module alu_ctrl_decode
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ALU_W-1:0] alu_control,
  output logic [REG_W-1:0] shamt,
  output logic [REG_W-1:0] rs_addr,
  output logic [REG_W-1:0] rt_addr,
  output logic [REG_W-1:0] dest_addr,
  output logic [XLEN-1:0]  imm32,
  output logic             use_imm,
  output logic             reg_write,
  output logic             is_load,
  output logic             is_store,
  output logic             illegal
);

  localparam int unsigned CNT_W = 2;

  if (DEPTH != 2) begin : g_bad_depth
    $fatal(1, "alu_ctrl_decode: only DEPTH=2 is supported");
  end

  dec_bundle_t       dec_c;
  dec_bundle_t       head_q, head_d;
  dec_bundle_t       tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              push_c, pop_c;

  alu_ctrl_decode_comb u_comb (
    .instr    (instr),
    .bundle_c (dec_c)
  );

  assign push_c = in_valid && in_ready_q;
  assign pop_c  = out_valid_q && out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Next-state: head is the oldest entry, tail only used when two are held
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (flush) begin
      count_d = '0;
    end else begin
      case (count_q)
        CNT_W'(0): begin
          if (push_c) begin
            head_d  = dec_c;
            count_d = CNT_W'(1);
          end
        end
        CNT_W'(1): begin
          if (push_c && pop_c) begin
            head_d = dec_c;
          end else if (push_c) begin
            tail_d  = dec_c;
            count_d = CNT_W'(2);
          end else if (pop_c) begin
            count_d = CNT_W'(0);
          end
        end
        CNT_W'(2): begin
          if (pop_c) begin
            head_d  = tail_q;
            count_d = CNT_W'(1);
          end
        end
        default: count_d = '0;
      endcase
    end

    out_valid_d = (count_d != '0);
    in_ready_d  = (count_d < CNT_W'(DEPTH));
  end

  // Outputs come straight from registers
  always_comb begin
    in_ready    = in_ready_q;
    out_valid   = out_valid_q;
    alu_control = head_q.alu_control;
    shamt       = head_q.shamt;
    rs_addr     = head_q.rs_addr;
    rt_addr     = head_q.rt_addr;
    dest_addr   = head_q.dest_addr;
    imm32       = head_q.imm32;
    use_imm     = head_q.use_imm;
    reg_write   = head_q.reg_write;
    is_load     = head_q.is_load;
    is_store    = head_q.is_store;
    illegal     = head_q.illegal;
  end

endmodule

// File: doc/alu_ctrl_decode.md
Name: alu_ctrl_decode

Overview:
Registered decode stage that turns a 32-bit MIPS instruction word into the operand, shamt and 5-bit alu_control bundle that the combinational ALU consumes. It sits between instruction fetch and execute.
- Valid/ready handshake on both sides, so fetch and execute can each stall.
- 2-entry skid buffer gives full throughput with a registered in_ready.
- Flags illegal encodings and supports a pipeline flush.

Parameters:
DEPTH, 2, skid-buffer entries; only 2 is supported, and elaboration fails otherwise.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
flush  input  1  drop all buffered entries this cycle
in_valid  input  1  instr is valid
in_ready  output  1  stage can accept instr; registered
instr  input  32  MIPS instruction word
out_valid  output  1  decoded bundle is valid
out_ready  input  1  execute accepts the bundle
alu_control  output  5  ALU opcode, using the shared encoding
shamt  output  5  instr[10:6] for R-type; 0 otherwise
rs_addr  output  5  instr[25:21]
rt_addr  output  5  instr[20:16]
dest_addr  output  5  write-back register
imm32  output  32  extended immediate
use_imm  output  1  ALU second operand is imm32 rather than rt
reg_write  output  1  result is written back
is_load  output  1  lw
is_store  output  1  sw
illegal  output  1  encoding not decoded

Behaviour:
- Reset: all outputs are synchronous to clk. While rst is high and in the first cycle after: out_valid=0, in_ready=1, both entries empty, all data outputs 0.
- Accept: an instr is accepted on a clk edge where in_valid && in_ready. Decode is combinational on instr and the result is stored in a buffer entry.
- Latency: the accepted instr appears with out_valid=1 in the next cycle.
- Throughput: with out_ready held high, one instr per cycle.
- Output stability: the bundle leaves on a clk edge where out_valid && out_ready. While out_valid=1 && out_ready=0, all outputs hold stable.
- Buffer control, count in 0..2:
  - in_ready = (count<2) as registered. Equivalently, in_ready deasserts the cycle after the buffer becomes full.
  - Simultaneous push and pop: count is unchanged and order is preserved FIFO.
  - Push at count 2 cannot occur, because in_ready=0.
- flush: at that edge count becomes 0, out_valid becomes 0 and in_ready becomes 1.
  - flush has priority over a same-cycle push or pop; the pushed instr is discarded.
- Mid-operation reset behaves identically to flush and additionally zeroes the data outputs.
- Decode, R-type (opcode 6'h00), by funct:
  - 00 sll, 02 srl, 03 sra, 04 sllv, 06 srlv, 07 srav
  - 20 add, 21 addu, 22 sub, 23 subu
  - 24 and, 25 or, 26 xor, 27 nor
  - 2a slt, 2b sltu
  - use_imm=0, dest=rd (instr[15:11]), shamt=instr[10:6].
- Decode, I-type, by opcode:
  - 08 add, 09 addu, 0a slt, 0b sltu: sign-extended immediate.
  - 0c and, 0d or, 0e xor: zero-extended immediate.
  - 0f lui: imm32 = {16'h0, instr[15:0]}; the ALU performs the shift.
  - 23 lw: addu, sign-extended immediate, is_load=1.
  - 2b sw: addu, sign-extended immediate, is_store=1, reg_write=0.
  - use_imm=1, dest=rt.
- reg_write=1 for every legal non-store op, except it is forced to 0 when dest_addr==0. Consequence: the all-zero nop decodes as a legal sll with reg_write=0.
- Illegal: any other opcode/funct gives illegal=1, alu_control=5'b11111, reg_write=0, is_load=0, is_store=0.
  - The entry still flows through the handshake normally and is not dropped.

Decomposition:
- Package alu_pkg holds:
  - the 5-bit ALU codes: sll 00000, srl 00001, sra 00010, sllv 00011, srlv 00100, srav 00101, add 00110, addu 00111, sub 01000, subu 01001, and 01010, or 01011, xor 01100, nor 01101, slt 01110, sltu 01111, lui 10000, illegal 11111;
  - opcode and funct constants;
  - the packed decoded-bundle struct.
- One sub-module, alu_ctrl_decode_comb: purely combinational instr -> bundle. The parent holds the skid buffer and the handshake.

Test Plan:
1. Reset, then stream instrs 0x012A4020 (add $8,$9,$10), 0x00094080 (sll $8,$9,2), 0x3C081234 (lui $8,0x1234) with out_ready=1.
   -> Outputs 1 cycle later, back-to-back: codes 00110/00000/10000; shamt=0/2/0; dest=8; imm32=0x00001234 on the lui.
2. Immediates: addi 0x2128FFFF and andi 0x3128FFFF.
   -> imm32=0xFFFFFFFF (code 00110) and imm32=0x0000FFFF (code 01010); use_imm=1; dest=8.
3. Backpressure: out_ready=0 with 3 instrs offered.
   -> 2 accepted, in_ready=0 from the next cycle, outputs frozen. Release out_ready -> FIFO order kept, no loss or duplication.
4. Flush with count=2 plus a same-cycle push.
   -> Next cycle out_valid=0, in_ready=1, and the pushed instr is never emitted.
5. 0xFC000000 and R-type funct 0x3F.
   -> illegal=1, code 11111, reg_write=0. Then nop 0x00000000 -> illegal=0, code 00000, reg_write=0.
6. sw 0xAD28FFFC and lw 0x8D28FFFC.
   -> code 00111, imm32=0xFFFFFFFC. sw: is_store=1, reg_write=0. lw: is_load=1, reg_write=1, dest=8.
